// File: rtl/por_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : por_sequencer
// Description : Power-on / soft reset sequencer. Holds CHANNELS downstream
//               domains in reset after configuration, then releases them in
//               ascending order, staggered by STAGGER_CYCLES, and drives a
//               heartbeat bit once every domain is running.
// Revision    : 1.0 - initial release
// ============================================================================
module por_sequencer #(
  parameter int CHANNELS       = 2,
  parameter int HOLD_CYCLES    = 127,
  parameter int STAGGER_CYCLES = 16,
  parameter int HB_WIDTH       = 24,
  parameter int HB_BIT         = 18
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                SoftReq,
  output logic [CHANNELS-1:0] RstOut,
  output logic                Running,
  output logic                Heartbeat
);

  // Cycle on which the last channel is released; the counter must reach it
  // without wrapping.
  localparam int LAST_CYCLES = HOLD_CYCLES + (CHANNELS - 1) * STAGGER_CYCLES;
  localparam int CW          = $clog2(LAST_CYCLES + 1);

  localparam logic [CW:0] LAST_V = (CW + 1)'(LAST_CYCLES);
  localparam logic [CW:0] HOLD_V = (CW + 1)'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Declaration values match the reset values so the sequence also starts
  // straight out of configuration without a Reset pulse.
  state_t                state       = ST_HOLD;
  logic [CW-1:0]         seq_cnt     = '0;
  logic [CHANNELS-1:0]   rst_q       = '1;
  logic                  running_q   = 1'b0;
  logic [HB_WIDTH-1:0]   hb_cnt      = '0;
  logic                  heartbeat_q = 1'b0;

  state_t                state_next;
  logic [CW-1:0]         seq_cnt_next;
  logic [CHANNELS-1:0]   rst_next;
  logic                  running_next;
  logic [HB_WIDTH-1:0]   hb_cnt_next;
  logic                  heartbeat_next;

  // Count value the register will hold after this edge; outputs are decoded
  // from it so they change in the same cycle the count crosses a threshold.
  logic [CW:0]           cnt_inc;
  logic [CHANNELS-1:0]   rel_mask;

  assign cnt_inc = {1'b0, seq_cnt} + (CW + 1)'(1);

  // Channel k stays in reset while the count is below its own threshold.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_thresh
    localparam logic [CW:0] THR = (CW + 1)'(HOLD_CYCLES + k * STAGGER_CYCLES);
    assign rel_mask[k] = (cnt_inc < THR);
  end

  // Next-state, counter and output decode for the sequencing FSM.
  always_comb begin
    state_next   = state;
    seq_cnt_next = seq_cnt;
    rst_next     = rst_q;
    running_next = running_q;
    if (SoftReq) begin
      state_next   = ST_HOLD;
      seq_cnt_next = '0;
      rst_next     = '1;
      running_next = 1'b0;
    end else begin
      case (state)
        ST_HOLD, ST_RELEASE: begin
          seq_cnt_next = cnt_inc[CW-1:0];
          rst_next     = rel_mask;
          if (cnt_inc >= LAST_V) begin
            state_next   = ST_RUN;
            running_next = 1'b1;
          end else if (cnt_inc >= HOLD_V) begin
            state_next = ST_RELEASE;
          end
        end
        ST_RUN: begin
          state_next = ST_RUN;
        end
        default: begin
          state_next   = ST_HOLD;
          seq_cnt_next = '0;
          rst_next     = '1;
          running_next = 1'b0;
        end
      endcase
    end
  end

  // Heartbeat counter runs only while staying in RUN and clears on any exit;
  // the output bit is gated by the next Running so it drops with Running.
  always_comb begin
    hb_cnt_next    = hb_cnt;
    heartbeat_next = 1'b0;
    if (state_next != ST_RUN) begin
      hb_cnt_next = '0;
    end else begin
      if (state == ST_RUN) begin
        hb_cnt_next = hb_cnt + HB_WIDTH'(1);
      end
      heartbeat_next = hb_cnt[HB_BIT];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state       <= ST_HOLD;
      seq_cnt     <= '0;
      rst_q       <= '1;
      running_q   <= 1'b0;
      hb_cnt      <= '0;
      heartbeat_q <= 1'b0;
    end else begin
      state       <= state_next;
      seq_cnt     <= seq_cnt_next;
      rst_q       <= rst_next;
      running_q   <= running_next;
      hb_cnt      <= hb_cnt_next;
      heartbeat_q <= heartbeat_next;
    end
  end

  assign RstOut    = rst_q;
  assign Running   = running_q;
  assign Heartbeat = heartbeat_q;

endmodule
`default_nettype wire

// File: tb/tb_por_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_por_sequencer
// Description : Scoreboard bench for por_sequencer. Four instances with
//               different parameter sets share the same Reset/SoftReq
//               stimulus; a cycle-age reference model predicts each output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_por_sequencer;

  localparam int NI = 4;

  // Instance parameter sets: defaults with a short heartbeat, the
  // all-together case, a 3-channel staggered case, and a single channel.
  localparam int CH0 = 2, H0 = 127, S0 = 16, W0 = 5,  B0 = 3;
  localparam int CH1 = 4, H1 = 1,   S1 = 0,  W1 = 4,  B1 = 2;
  localparam int CH2 = 3, H2 = 5,   S2 = 3,  W2 = 3,  B2 = 2;
  localparam int CH3 = 1, H3 = 3,   S3 = 7,  W3 = 24, B3 = 0;

  logic clk = 1'b1;
  logic Reset;
  logic SoftReq;

  logic [CH0-1:0] rst0;
  logic [CH1-1:0] rst1;
  logic [CH2-1:0] rst2;
  logic [CH3-1:0] rst3;
  logic [NI-1:0]  run_o;
  logic [NI-1:0]  hb_o;

  logic [NI-1:0][7:0] act_rst;
  assign act_rst[0] = 8'(rst0);
  assign act_rst[1] = 8'(rst1);
  assign act_rst[2] = 8'(rst2);
  assign act_rst[3] = 8'(rst3);

  always #5 clk = ~clk;

  por_sequencer #(.CHANNELS(CH0), .HOLD_CYCLES(H0), .STAGGER_CYCLES(S0), .HB_WIDTH(W0), .HB_BIT(B0))
    dut0 (.CLK(clk), .Reset(Reset), .SoftReq(SoftReq), .RstOut(rst0), .Running(run_o[0]), .Heartbeat(hb_o[0]));
  por_sequencer #(.CHANNELS(CH1), .HOLD_CYCLES(H1), .STAGGER_CYCLES(S1), .HB_WIDTH(W1), .HB_BIT(B1))
    dut1 (.CLK(clk), .Reset(Reset), .SoftReq(SoftReq), .RstOut(rst1), .Running(run_o[1]), .Heartbeat(hb_o[1]));
  por_sequencer #(.CHANNELS(CH2), .HOLD_CYCLES(H2), .STAGGER_CYCLES(S2), .HB_WIDTH(W2), .HB_BIT(B2))
    dut2 (.CLK(clk), .Reset(Reset), .SoftReq(SoftReq), .RstOut(rst2), .Running(run_o[2]), .Heartbeat(hb_o[2]));
  por_sequencer #(.CHANNELS(CH3), .HOLD_CYCLES(H3), .STAGGER_CYCLES(S3), .HB_WIDTH(W3), .HB_BIT(B3))
    dut3 (.CLK(clk), .Reset(Reset), .SoftReq(SoftReq), .RstOut(rst3), .Running(run_o[3]), .Heartbeat(hb_o[3]));

  function automatic int p_ch(input int i);
    case (i) 0: return CH0; 1: return CH1; 2: return CH2; default: return CH3; endcase
  endfunction
  function automatic int p_h(input int i);
    case (i) 0: return H0; 1: return H1; 2: return H2; default: return H3; endcase
  endfunction
  function automatic int p_s(input int i);
    case (i) 0: return S0; 1: return S1; 2: return S2; default: return S3; endcase
  endfunction
  function automatic int p_w(input int i);
    case (i) 0: return W0; 1: return W1; 2: return W2; default: return W3; endcase
  endfunction
  function automatic int p_b(input int i);
    case (i) 0: return B0; 1: return B1; 2: return B2; default: return B3; endcase
  endfunction

  typedef struct packed {
    logic [NI-1:0][7:0] rst;
    logic [NI-1:0]      run;
    logic [NI-1:0]      hb;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Sequence age: cycle number within the current sequence, 1 = first cycle.
  int   age[NI];

  // Expected outputs for instance i in a cycle of the given age, straight
  // from the timing rules: channel k held for H + k*S cycles, running after
  // the last release, heartbeat = bit B of the run-cycle count one cycle late.
  function automatic void predict(input int i, input int a,
                                  output logic [7:0] r, output logic run, output logic hb);
    int last;
    longint m;
    longint c;
    r = 8'h00;
    for (int k = 0; k < p_ch(i); k++) begin
      r[k] = (a <= p_h(i) + k * p_s(i));
    end
    last = p_h(i) + (p_ch(i) - 1) * p_s(i);
    run  = (a > last);
    hb   = 1'b0;
    if (run) begin
      m = longint'(a) - longint'(last) - 1;
      if (m >= 1) begin
        c  = (m - 1) % (longint'(1) << p_w(i));
        hb = ((c >> p_b(i)) & 1) == 1;
      end
    end
  endfunction

  function automatic exp_t build_exp();
    exp_t e;
    e = '0;
    for (int i = 0; i < NI; i++) begin
      predict(i, age[i], e.rst[i], e.run[i], e.hb[i]);
    end
    return e;
  endfunction

  // Reference model: advances the sequence age each edge and queues the
  // expected outputs for the cycle that follows.
  initial begin
    for (int i = 0; i < NI; i++) age[i] = 1;
    sbq.push_back(build_exp());
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!Reset || SoftReq) age[i] = 1;
        else if (age[i] < 32'h3fff_ffff) age[i] = age[i] + 1;
      end
      sbq.push_back(build_exp());
    end
  end

  // Monitor: outputs are valid every cycle; sample mid-cycle and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty t=%0t actual=no_expectation required=one_entry", $time);
      end else begin
        e = sbq.pop_front();
        for (int i = 0; i < NI; i++) begin
          checks++;
          if (act_rst[i] !== e.rst[i]) begin
            failures++;
            $display("FAIL rstout[%0d] t=%0t actual=%b required=%b", i, $time, act_rst[i], e.rst[i]);
          end
          checks++;
          if (run_o[i] !== e.run[i]) begin
            failures++;
            $display("FAIL running[%0d] t=%0t actual=%b required=%b", i, $time, run_o[i], e.run[i]);
          end
          checks++;
          if (hb_o[i] !== e.hb[i]) begin
            failures++;
            $display("FAIL heartbeat[%0d] t=%0t actual=%b required=%b", i, $time, hb_o[i], e.hb[i]);
          end
        end
      end
    end
  end

  task automatic drive(input logic r, input logic s, input int n);
    repeat (n) begin
      @(negedge clk);
      Reset   = r;
      SoftReq = s;
    end
  endtask

  // Stimulus: directed scenarios followed by randomized Reset/SoftReq.
  initial begin
    int hold;
    Reset   = 1'b1;
    SoftReq = 1'b0;
    // Power-up with Reset never asserted; covers full release and heartbeat.
    drive(1, 0, 200);
    // Reset pulse, then Reset low for 3 cycles at cycle 135 (mid-release).
    drive(0, 0, 1);
    drive(1, 0, 134);
    drive(0, 0, 3);
    drive(1, 0, 300);
    // SoftReq pulse while running.
    drive(1, 1, 1);
    drive(1, 0, 300);
    // Reset together with SoftReq, then SoftReq held for 10 cycles.
    drive(0, 1, 1);
    drive(1, 0, 200);
    drive(1, 1, 10);
    drive(1, 0, 300);
    // Randomized requests, occasionally held for several cycles.
    repeat (3000) begin
      @(negedge clk);
      Reset   = ($urandom_range(0, 399) != 0);
      SoftReq = ($urandom_range(0, 249) == 0);
      if (SoftReq && $urandom_range(0, 3) == 0) begin
        hold = $urandom_range(1, 6);
        drive(Reset, 1'b1, hold);
      end
    end
    drive(1, 0, 200);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
